// File: rtl/cla_nibble_serial_sub.sv
// Nibble-serial multi-word subtractor: 4-bit borrow-lookahead per nibble, borrow
// carried between nibbles in a register, registered valid/ready result stream.
module cla_nibble_serial_sub #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_first,
  input  logic       in_bin,
  input  logic [3:0] in_a,
  input  logic [3:0] in_b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_d,
  output logic       out_last,
  output logic       out_bout,
  output logic       out_zero,
  output logic       err
);

  localparam int unsigned CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NIBBLES - 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             borrow_q, borrow_d;
  logic             zero_acc_q, zero_acc_d;
  logic             err_q, err_d;
  logic             out_valid_q, out_valid_d;
  logic [3:0]       out_d_q, out_d_d;
  logic             out_last_q, out_last_d;
  logic             out_bout_q, out_bout_d;
  logic             out_zero_q, out_zero_d;

  logic       accept;
  logic       bi;
  logic [3:0] g, p;
  logic [4:0] bc;
  logic [3:0] diff;
  logic       bout;
  logic       diff_zero;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Borrow-in select and expanded 4-bit borrow lookahead
  always_comb begin
    bi = borrow_q;
    if (state_q == IDLE) begin
      bi = in_first ? in_bin : 1'b0;
    end else if (in_first) begin
      bi = in_bin;
    end
    g = ~in_a & in_b;
    p = ~(in_a ^ in_b);
    bc[0] = bi;
    bc[1] = g[0] | (p[0] & bi);
    bc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bi);
    bc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bi);
    bc[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & bi);
    diff      = in_a ^ in_b ^ bc[3:0];
    bout      = bc[4];
    diff_zero = (diff == 4'd0);
  end

  // Next-state and output register logic
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    borrow_d    = borrow_q;
    zero_acc_d  = zero_acc_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    out_d_d     = out_d_q;
    out_last_d  = out_last_q;
    out_bout_d  = out_bout_q;
    out_zero_d  = out_zero_q;

    if (accept) begin
      out_valid_d = 1'b1;
      out_d_d     = diff;
      out_last_d  = 1'b0;
      out_bout_d  = 1'b0;
      out_zero_d  = 1'b0;
      borrow_d    = bout;
      if ((state_q == IDLE && !in_first) || (state_q == BUSY && in_first)) begin
        err_d = 1'b1;
      end
      if (state_q == IDLE || in_first) begin
        // Start (or abortive restart) of a word
        state_d    = BUSY;
        idx_d      = CNT_W'(1);
        zero_acc_d = diff_zero;
      end else if (idx_q == LAST_IDX) begin
        state_d    = IDLE;
        idx_d      = '0;
        zero_acc_d = 1'b1;
        out_last_d = 1'b1;
        out_bout_d = bout;
        out_zero_d = zero_acc_q & diff_zero;
      end else begin
        idx_d      = idx_q + CNT_W'(1);
        zero_acc_d = zero_acc_q & diff_zero;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      borrow_q    <= 1'b0;
      zero_acc_q  <= 1'b1;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_d_q     <= 4'd0;
      out_last_q  <= 1'b0;
      out_bout_q  <= 1'b0;
      out_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      borrow_q    <= borrow_d;
      zero_acc_q  <= zero_acc_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_d_q     <= out_d_d;
      out_last_q  <= out_last_d;
      out_bout_q  <= out_bout_d;
      out_zero_q  <= out_zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_d     = out_d_q;
  assign out_last  = out_last_q;
  assign out_bout  = out_bout_q;
  assign out_zero  = out_zero_q;
  assign err       = err_q;

endmodule

// File: tb/tb_cla_nibble_serial_sub.sv
// Bench for cla_nibble_serial_sub: whole-word subtraction reference model feeding an
// expected-nibble queue, checked every cycle with immediate assertions.
module tb_cla_nibble_serial_sub;

  localparam int NIB = 4;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       in_first;
  logic       in_bin;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_d;
  logic       out_last;
  logic       out_bout;
  logic       out_zero;
  logic       err;

  cla_nibble_serial_sub #(.NIBBLES(NIB)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_first (in_first),
    .in_bin   (in_bin),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_d    (out_d),
    .out_last (out_last),
    .out_bout (out_bout),
    .out_zero (out_zero),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] d;
    logic       last;
    logic       bout;
    logic       zero;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic rdy_s;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare the output stream against the head of the expected queue
  task automatic check_out();
    chk("out_valid", 16'(out_valid), 16'(q.size() != 0));
    if (out_valid && q.size() != 0) begin
      chk("out_d",    16'(out_d),    16'(q[0].d));
      chk("out_last", 16'(out_last), 16'(q[0].last));
      chk("out_bout", 16'(out_bout), 16'(q[0].bout));
      chk("out_zero", 16'(out_zero), 16'(q[0].zero));
      if (out_ready) void'(q.pop_front());
    end
  endtask

  // One clock: sample at negedge, return at posedge+1
  task automatic tick();
    @(negedge clk);
    rdy_s = in_ready;
    if (!rst) check_out();
    @(posedge clk);
    #1;
  endtask

  // Send n_sent nibbles of A-B; model is plain wide arithmetic on the whole word
  task automatic send_word(input logic [15:0] a, input logic [15:0] b, input logic bin,
                           input logic first0, input int n_sent, input int stall_at);
    logic [16:0] full;
    logic        eff;
    logic        accepted;
    exp_t        e;
    eff  = first0 ? bin : 1'b0;
    full = {1'b0, a} - {1'b0, b} - 17'(eff);
    for (int i = 0; i < n_sent; i++) begin
      in_valid = 1'b1;
      in_first = (i == 0) ? first0 : 1'b0;
      in_bin   = (i == 0) ? bin : 1'($urandom);
      in_a     = a[4*i +: 4];
      in_b     = b[4*i +: 4];
      if (i == stall_at) begin
        out_ready = 1'b0;
        repeat (3) begin
          tick();
          chk("in_ready_stall", 16'(rdy_s), 16'd0);
        end
        out_ready = 1'b1;
      end
      tick();
      chk("in_ready", 16'(rdy_s), 16'd1);
      accepted = rdy_s;
      for (int k = 0; k < 20 && !accepted; k++) begin
        tick();
        accepted = rdy_s;
      end
      if (!accepted) chk("accept_timeout", 16'd0, 16'd1);
      e.d    = full[4*i +: 4];
      e.last = (i == NIB - 1);
      e.bout = e.last ? full[16] : 1'b0;
      e.zero = e.last ? (full[15:0] == 16'd0) : 1'b0;
      q.push_back(e);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_first  = 1'b0;
    in_bin    = 1'b0;
    in_a      = 4'd0;
    in_b      = 4'd0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_in_ready",  16'(in_ready),  16'd1);
    chk("rst_out_d",     16'(out_d),     16'd0);
    chk("rst_out_last",  16'(out_last),  16'd0);
    chk("rst_out_bout",  16'(out_bout),  16'd0);
    chk("rst_out_zero",  16'(out_zero),  16'd0);
    chk("rst_err",       16'(err),       16'd0);
    rst = 1'b0;

    // Directed words, back to back
    send_word(16'h1234, 16'h0234, 1'b0, 1'b1, NIB, -1);
    send_word(16'h0000, 16'h0001, 1'b0, 1'b1, NIB, -1);
    send_word(16'hABCD, 16'hABCC, 1'b1, 1'b1, NIB, -1);
    chk("err_clean", 16'(err), 16'd0);

    // Backpressure mid-word
    send_word(16'h5A3C, 16'h1F77, 1'b1, 1'b1, NIB, 2);
    for (int w = 0; w < 12; w++) begin
      send_word(16'($urandom), 16'($urandom), 1'($urandom), 1'b1, NIB,
                ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, NIB - 1)) : -1);
    end
    chk("err_clean2", 16'(err), 16'd0);

    // Protocol: first nibble without in_first -> borrow-in forced to 0
    send_word(16'h0100, 16'h0000, 1'b1, 1'b0, NIB, -1);
    chk("err_set", 16'(err), 16'd1);

    // Abort after 2 nibbles by reasserting in_first
    send_word(16'h4321, 16'h8765, 1'b0, 1'b1, 2, -1);
    send_word(16'h9000, 16'h8FFF, 1'b1, 1'b1, NIB, -1);
    chk("err_sticky", 16'(err), 16'd1);

    // Reset after the 2nd nibble
    send_word(16'h7777, 16'h1111, 1'b0, 1'b1, 2, -1);
    rst = 1'b1;
    q.delete();
    #1;
    chk("mid_rst_out_valid", 16'(out_valid), 16'd0);
    chk("mid_rst_in_ready",  16'(in_ready),  16'd1);
    chk("mid_rst_err",       16'(err),       16'd0);
    tick();
    tick();
    rst = 1'b0;
    send_word(16'h0010, 16'h0001, 1'b0, 1'b1, NIB, -1);
    chk("err_after_rst", 16'(err), 16'd0);

    for (int w = 0; w < 10; w++) begin
      send_word(16'($urandom), 16'($urandom), 1'($urandom), 1'b1, NIB,
                ($urandom_range(0, 3) == 0) ? 1 : -1);
    end

    for (int k = 0; k < 20 && q.size() != 0; k++) tick();
    chk("drain", 16'(q.size()), 16'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
